// File: rtl/cache_pkg.sv
// Shared types and address helpers for the write-back data cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
    FLUSH_WB,
    DONE
  } state_t;

  // Field widths as functions of geometry, so each instance derives its own.
  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int woff_w(int words);
    return (words > 1) ? $clog2(words) : 0;
  endfunction

  // Word counter needs at least one bit even for single-word blocks.
  function automatic int cnt_w(int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int tag_w(int sets, int words);
    return 30 - idx_w(sets) - woff_w(words);
  endfunction

  localparam int SETS_DEF  = 8;
  localparam int WORDS_DEF = 2;
  localparam int IDX_W     = idx_w(SETS_DEF);
  localparam int WOFF_W    = woff_w(WORDS_DEF);
  localparam int TAG_W     = tag_w(SETS_DEF, WORDS_DEF);

  // Fields are kept 32 bits wide; users slice the low bits they need.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] idx;
    logic [31:0] woff;
    logic [1:0]  boff;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(logic [31:0] addr, int sets, int words);
    addr_fields_t f;
    f.boff = addr[1:0];
    f.woff = (addr >> 2) & 32'(words - 1);
    f.idx  = (addr >> (2 + woff_w(words))) & 32'(sets - 1);
    f.tag  = addr >> (2 + woff_w(words) + idx_w(sets));
    return f;
  endfunction

  function automatic logic [31:0] make_addr(logic [31:0] tag, logic [31:0] idx,
                                            logic [31:0] word, int sets, int words);
    return (tag << (2 + woff_w(words) + idx_w(sets))) |
           (idx << (2 + woff_w(words))) | (word << 2);
  endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Valid/dirty/tag/data storage for every way of every set plus per-set LRU.
// All ways of one set are read combinationally; one write port updates a word,
// the fill tag, a dirty flag or the LRU bit of a single frame.
module dcache_frame_array import cache_pkg::*; #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int WORDS    = 2,
  parameter int TAG_BITS = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [idx_w(SETS)-1:0]         rd_idx,
  input  logic [cnt_w(WORDS)-1:0]        rd_word,
  output logic [WAYS-1:0]                valid,
  output logic [WAYS-1:0]                dirty,
  output logic [WAYS-1:0][TAG_BITS-1:0]  tag,
  output logic [WAYS-1:0][31:0]          word,
  output logic                           lru,
  input  logic                           wr_way,
  input  logic [idx_w(SETS)-1:0]         wr_idx,
  input  logic [cnt_w(WORDS)-1:0]        wr_word,
  input  logic                           we_data,
  input  logic [31:0]                    wr_data,
  input  logic                           we_fill,
  input  logic [TAG_BITS-1:0]            wr_tag,
  input  logic                           we_dirty,
  input  logic                           wr_dirty,
  input  logic                           we_lru,
  input  logic                           wr_lru
);

  logic                v_q [WAYS][SETS];
  logic                d_q [WAYS][SETS];
  logic                l_q [SETS];
  logic [TAG_BITS-1:0] t_q [WAYS][SETS];
  logic [31:0]         m_q [WAYS][SETS][WORDS];

  // Flags: cleared on reset; a fill marks the frame valid and clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          v_q[w][s] <= 1'b0;
          d_q[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < SETS; s++) l_q[s] <= 1'b0;
    end else begin
      if (we_fill) begin
        v_q[wr_way][wr_idx] <= 1'b1;
        d_q[wr_way][wr_idx] <= 1'b0;
      end
      if (we_dirty) d_q[wr_way][wr_idx] <= wr_dirty;
      if (we_lru)   l_q[wr_idx] <= wr_lru;
    end
  end

  // Tag and data arrays carry no reset; valid qualifies their contents.
  always_ff @(posedge clk) begin
    if (we_fill) t_q[wr_way][wr_idx] <= wr_tag;
    if (we_data) m_q[wr_way][wr_idx][wr_word] <= wr_data;
  end

  // Combinational read of every way in the addressed set.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      valid[w] = v_q[w][rd_idx];
      dirty[w] = d_q[w][rd_idx];
      tag[w]   = t_q[w][rd_idx];
      word[w]  = m_q[w][rd_idx][rd_word];
    end
    lru = l_q[rd_idx];
  end

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate data cache with halt-triggered flush.
//   state    | meaning
//   IDLE     | serve hits, detect misses, sample halt
//   WB       | write dirty victim back, one word per accepted beat
//   FETCH    | fill victim frame from memory, then return to IDLE
//   FLUSH    | visit next frame (set-major), skip it if clean
//   FLUSH_WB | write the visited dirty frame back
//   DONE     | flush complete; flushed held until reset
module dcache_wb import cache_pkg::*; #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int IDX_BITS = idx_w(SETS);
  localparam int CNT_BITS = cnt_w(WORDS);
  localparam int TAG_BITS = tag_w(SETS, WORDS);

  state_t state, state_n;

  addr_fields_t              fa;
  logic [TAG_BITS-1:0]       req_tag, req_tag_q;
  logic [IDX_BITS-1:0]       req_idx, req_idx_q, fl_idx, rd_idx, wr_idx;
  logic [CNT_BITS-1:0]       req_woff, cnt, rd_word, wr_word;
  logic                      vic_way, vic_sel, fl_way, hit, hit_way;
  logic [WAYS-1:0]           hit_vec, fr_valid, fr_dirty;
  logic [WAYS-1:0][TAG_BITS-1:0] fr_tag;
  logic [WAYS-1:0][31:0]     fr_word;
  logic                      fr_lru, req, last_word, frame_dirty, step_frame, flushing;
  logic                      wr_way, we_data, we_fill, we_dirty, wr_dirty, we_lru, wr_lru;
  logic [31:0]               wr_data;
  logic [TAG_BITS-1:0]       wr_tag;
  logic                      unused_bits;

  assign fa          = split_addr(dmemaddr, SETS, WORDS);
  assign req_tag     = fa.tag[TAG_BITS-1:0];
  assign req_idx     = fa.idx[IDX_BITS-1:0];
  assign req_woff    = fa.woff[CNT_BITS-1:0];
  assign unused_bits = ^{fa.boff, fa.tag[31:TAG_BITS], fa.idx[31:IDX_BITS], fa.woff[31:CNT_BITS]};

  assign req         = dmemREN | dmemWEN;
  assign last_word   = (cnt == CNT_BITS'(WORDS - 1));
  assign flushing    = (state == FLUSH) || (state == FLUSH_WB);
  assign rd_idx      = (state == IDLE) ? req_idx : (flushing ? fl_idx : req_idx_q);
  assign rd_word     = (state == IDLE) ? req_woff : cnt;
  assign frame_dirty = fr_valid[fl_way] & fr_dirty[fl_way];
  assign step_frame  = ((state == FLUSH) && !frame_dirty) ||
                       ((state == FLUSH_WB) && !dwait && last_word);

  dcache_frame_array #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .TAG_BITS(TAG_BITS)) u_frames (
    .clk(CLK), .rst(RST),
    .rd_idx(rd_idx), .rd_word(rd_word),
    .valid(fr_valid), .dirty(fr_dirty), .tag(fr_tag), .word(fr_word), .lru(fr_lru),
    .wr_way(wr_way), .wr_idx(wr_idx), .wr_word(wr_word),
    .we_data(we_data), .wr_data(wr_data), .we_fill(we_fill), .wr_tag(wr_tag),
    .we_dirty(we_dirty), .wr_dirty(wr_dirty), .we_lru(we_lru), .wr_lru(wr_lru)
  );

  // Hit detection across ways and victim choice: invalid way first, else LRU.
  always_comb begin
    for (int w = 0; w < WAYS; w++) hit_vec[w] = fr_valid[w] && (fr_tag[w] == req_tag);
    hit     = |hit_vec;
    hit_way = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;
    if (!fr_valid[0])                        vic_sel = 1'b0;
    else if (WAYS == 2 && !fr_valid[WAYS-1]) vic_sel = 1'b1;
    else                                     vic_sel = (WAYS == 2) ? fr_lru : 1'b0;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; halt in IDLE outranks any pending request.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (halt) state_n = FLUSH;
                else if (req && !hit)
                  state_n = (fr_valid[vic_sel] && fr_dirty[vic_sel]) ? WB : FETCH;
      WB:       if (!dwait && last_word) state_n = FETCH;
      FETCH:    if (!dwait && last_word) state_n = IDLE;
      FLUSH:    if (frame_dirty) state_n = FLUSH_WB;
                else if (step_frame && fl_idx == IDX_BITS'(SETS - 1) && fl_way == 1'(WAYS - 1))
                  state_n = DONE;
      FLUSH_WB: if (step_frame)
                  state_n = (fl_idx == IDX_BITS'(SETS - 1) && fl_way == 1'(WAYS - 1)) ? DONE : FLUSH;
      DONE:     state_n = DONE;
      default:  state_n = IDLE;
    endcase
  end

  // Miss context, word counter and flush scan position.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      vic_way   <= 1'b0;
      req_tag_q <= '0;
      req_idx_q <= '0;
      fl_idx    <= '0;
      fl_way    <= 1'b0;
    end else begin
      if (state == IDLE && !halt && req && !hit) begin
        vic_way   <= vic_sel;
        req_tag_q <= req_tag;
        req_idx_q <= req_idx;
      end
      if ((state == WB || state == FETCH || state == FLUSH_WB) && !dwait)
        cnt <= last_word ? '0 : cnt + CNT_BITS'(1);
      else if (state == IDLE || state == FLUSH)
        cnt <= '0;
      if (state == IDLE) begin
        fl_idx <= '0;
        fl_way <= 1'b0;
      end else if (step_frame) begin
        if (fl_way == 1'(WAYS - 1)) begin
          fl_way <= 1'b0;
          fl_idx <= fl_idx + IDX_BITS'(1);
        end else begin
          fl_way <= 1'b1;
        end
      end
    end
  end

  // Outputs and frame-array write controls per state.
  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    we_data  = 1'b0;
    we_fill  = 1'b0;
    we_dirty = 1'b0;
    we_lru   = 1'b0;
    wr_way   = vic_way;
    wr_idx   = req_idx_q;
    wr_word  = cnt;
    wr_data  = dload;
    wr_tag   = req_tag_q;
    wr_dirty = 1'b0;
    wr_lru   = 1'b0;
    case (state)
      IDLE: if (!halt && req && hit) begin
        dhit     = 1'b1;
        dmemload = fr_word[hit_way];
        wr_way   = hit_way;
        wr_idx   = req_idx;
        we_lru   = (WAYS == 2);
        wr_lru   = ~hit_way;
        if (dmemWEN) begin
          we_data  = 1'b1;
          wr_word  = req_woff;
          wr_data  = dmemstore;
          we_dirty = 1'b1;
          wr_dirty = 1'b1;
        end
      end
      WB: begin
        dWEN     = 1'b1;
        daddr    = make_addr(32'(fr_tag[vic_way]), 32'(req_idx_q), 32'(cnt), SETS, WORDS);
        dstore   = fr_word[vic_way];
        we_dirty = !dwait && last_word;
      end
      FETCH: begin
        dREN    = 1'b1;
        daddr   = make_addr(32'(req_tag_q), 32'(req_idx_q), 32'(cnt), SETS, WORDS);
        we_data = !dwait;
        we_fill = !dwait && last_word;
      end
      FLUSH_WB: begin
        dWEN     = 1'b1;
        daddr    = make_addr(32'(fr_tag[fl_way]), 32'(fl_idx), 32'(cnt), SETS, WORDS);
        dstore   = fr_word[fl_way];
        wr_way   = fl_way;
        wr_idx   = fl_idx;
        we_dirty = !dwait && last_word;
      end
      DONE: flushed = 1'b1;
      default: ;
    endcase
  end

endmodule
